// File: rtl/uart_rx_frame.sv
// uart_rx_frame
// UART receive datapath. Oversamples the serial line using the sample_enable
// strobe from the Rx baud controller (OVERSAMPLE strobes per bit). It validates
// the start bit at mid-bit, shifts data in LSB-first, and checks parity and the
// stop bit. It then presents one parallel byte per frame with status flags.
//
// Ports:
//   clk           system clock
//   rst           asynchronous, active-high reset
//   rx_en         receiver enable; low forces IDLE and drops any partial frame
//   sample_enable one-clk strobe, OVERSAMPLE per bit period
//   rxd           asynchronous serial line, idle high
//   rx_data       last received data word, held until the next frame completes
//   rx_valid      one-clk pulse when rx_data and the flags update
//   rx_perror     parity error of the last frame
//   rx_ferror     framing error (stop bit sampled low) of the last frame
module uart_rx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 sample_enable,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_perror,
  output logic                 rx_ferror
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t                 state_q;
  logic [3:0]             tick_cnt_q;
  logic [2:0]             bit_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   perr_q;
  logic                   rxd_meta_q;
  logic                   rxd_s_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   rx_valid_q;
  logic                   rx_perror_q;
  logic                   rx_ferror_q;

  // Two-flop synchronizer. It resets to the idle line level so that leaving
  // reset does not look like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // Frame FSM with registered outputs. Disabling the receiver takes priority
  // over the baud strobe, so a partial frame is discarded even when no tick
  // is pending. The start bit is checked at mid-bit. After that, each later
  // bit is sampled one full bit period after the previous sample, which keeps
  // every sample near the middle of its bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_perror_q <= 1'b0;
      rx_ferror_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (!rx_en) begin
        state_q    <= ST_IDLE;
        tick_cnt_q <= '0;
        bit_cnt_q  <= '0;
      end else if (sample_enable) begin
        case (state_q)
          ST_IDLE: begin
            if (!rxd_s_q) begin
              state_q    <= ST_START;
              tick_cnt_q <= '0;
            end
          end
          ST_START: begin
            if (tick_cnt_q == TICK_MID) begin
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
              state_q    <= rxd_s_q ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
          ST_DATA: begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_q <= '0;
              shift_q    <= {rxd_s_q, shift_q[DATA_BITS-1:1]};
              if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_q <= '0;
                state_q   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
          ST_PARITY: begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_q <= '0;
              perr_q     <= (^shift_q) ^ rxd_s_q ^ (PARITY_ODD != 0);
              state_q    <= ST_STOP;
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
          ST_STOP: begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_q  <= '0;
              rx_data_q   <= shift_q;
              rx_valid_q  <= 1'b1;
              rx_perror_q <= (PARITY_EN != 0) ? perr_q : 1'b0;
              rx_ferror_q <= ~rxd_s_q;
              state_q     <= rxd_s_q ? ST_IDLE : ST_BREAK;
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
          // A low stop bit may be a break condition. Waiting for the line to
          // return high prevents a held-low line from being taken as a new start.
          ST_BREAK: begin
            if (rxd_s_q) begin
              state_q <= ST_IDLE;
            end
          end
          default: begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
          end
        endcase
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_perror = rx_perror_q;
  assign rx_ferror = rx_ferror_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame
// Directed bench for uart_rx_frame with default parameters. sample_enable
// fires every 4 clk, so one bit period is 64 clk. Frames are driven on the
// falling clock edge. A monitor records every rx_valid pulse, and the main
// sequence compares the recorded values with hand-computed expectations.
module tb_uart_rx_frame;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_en;
  logic       sample_enable;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_perror;
  logic       rx_ferror;

  int         errors = 0;
  int         checks = 0;
  int         validCount = 0;
  int         multiHigh = 0;
  int         seCnt = 0;
  int         base;
  logic       prevValid = 1'b0;
  logic [7:0] lastData = 8'h00;
  logic       lastPe = 1'b0;
  logic       lastFe = 1'b0;

  uart_rx_frame #(
    .DATA_BITS (8),
    .OVERSAMPLE(16),
    .PARITY_EN (1),
    .PARITY_ODD(0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_en        (rx_en),
    .sample_enable(sample_enable),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_perror    (rx_perror),
    .rx_ferror    (rx_ferror)
  );

  always #5 clk = ~clk;

  // Baud strobe: one clk high out of every four.
  initial begin
    sample_enable = 1'b0;
    forever begin
      @(negedge clk);
      sample_enable = (seCnt == 3);
      seCnt = (seCnt + 1) % 4;
    end
  end

  // Pulse recorder: counts rx_valid pulses, latches the data and flags, and
  // counts any pulse that lasts longer than one clk.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        validCount++;
        lastData = rx_data;
        lastPe   = rx_perror;
        lastFe   = rx_ferror;
        if (prevValid) multiHigh++;
      end
      prevValid = (rx_valid === 1'b1);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkFrame(input string tag, input int expCount, input logic [7:0] expData,
                            input logic expPe, input logic expFe);
    checkOutput({tag, "_count"}, validCount, expCount);
    checkOutput({tag, "_data"}, {24'h0, lastData}, {24'h0, expData});
    checkOutput({tag, "_perror"}, {31'h0, lastPe}, {31'h0, expPe});
    checkOutput({tag, "_ferror"}, {31'h0, lastFe}, {31'h0, expFe});
  endtask

  task automatic holdLine(input logic level, input int clks);
    rxd = level;
    repeat (clks) @(negedge clk);
  endtask

  // Full frame: start, 8 data bits LSB-first, the given parity bit, the given stop bit.
  task automatic applyStimulus(input logic [7:0] data, input logic parityBit,
                               input logic stopBit);
    holdLine(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) holdLine(data[i], BIT_CLKS);
    holdLine(parityBit, BIT_CLKS);
    holdLine(stopBit, BIT_CLKS);
  endtask

  // Start bit and data bits 0..3 of 0xC3, then half of data bit 4.
  task automatic applyPartial();
    logic [7:0] pat;
    pat = 8'hC3;
    holdLine(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) holdLine(pat[i], BIT_CLKS);
    holdLine(pat[4], BIT_CLKS / 2);
  endtask

  initial begin
    rst   = 1'b1;
    rx_en = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_data", {24'h0, rx_data}, 32'h0);
    checkOutput("reset_valid", {31'h0, rx_valid}, 32'h0);
    checkOutput("reset_perror", {31'h0, rx_perror}, 32'h0);
    checkOutput("reset_ferror", {31'h0, rx_ferror}, 32'h0);
    rst = 1'b0;
    holdLine(1'b1, BIT_CLKS);

    // 0xA5 has four ones, so even parity is 0.
    base = validCount;
    applyStimulus(8'hA5, 1'b0, 1'b1);
    checkFrame("a5", base + 1, 8'hA5, 1'b0, 1'b0);
    checkOutput("a5_pulse_width", multiHigh, 0);
    holdLine(1'b1, BIT_CLKS);
    checkOutput("a5_data_held", {24'h0, rx_data}, 32'hA5);
    checkOutput("valid_low_idle", {31'h0, rx_valid}, 32'h0);

    // Wrong parity bit.
    base = validCount;
    applyStimulus(8'hA5, 1'b1, 1'b1);
    checkFrame("a5_badpar", base + 1, 8'hA5, 1'b1, 1'b0);
    holdLine(1'b1, BIT_CLKS);

    // Clean 0x3C clears the parity error.
    base = validCount;
    applyStimulus(8'h3C, 1'b0, 1'b1);
    checkFrame("3c", base + 1, 8'h3C, 1'b0, 1'b0);
    holdLine(1'b1, BIT_CLKS);

    // 0x55 with stop 0, line low for 3 more bit periods, then idle.
    base = validCount;
    applyStimulus(8'h55, 1'b0, 1'b0);
    checkFrame("55_stop0", base + 1, 8'h55, 1'b0, 1'b1);
    holdLine(1'b0, 3 * BIT_CLKS);
    holdLine(1'b1, BIT_CLKS);
    checkOutput("break_no_frame", validCount, base + 1);
    base = validCount;
    applyStimulus(8'h0F, 1'b0, 1'b1);
    checkFrame("0f_after_break", base + 1, 8'h0F, 1'b0, 1'b0);
    holdLine(1'b1, BIT_CLKS);

    // Low glitch of 4 ticks.
    base = validCount;
    holdLine(1'b0, 16);
    holdLine(1'b1, 2 * BIT_CLKS);
    checkOutput("glitch_no_frame", validCount, base);
    applyStimulus(8'h81, 1'b0, 1'b1);
    checkFrame("81", base + 1, 8'h81, 1'b0, 1'b0);
    holdLine(1'b1, BIT_CLKS);

    // Back-to-back frames with no idle gap.
    base = validCount;
    applyStimulus(8'h00, 1'b0, 1'b1);
    checkFrame("b2b_00", base + 1, 8'h00, 1'b0, 1'b0);
    applyStimulus(8'hFF, 1'b0, 1'b1);
    checkFrame("b2b_ff", base + 2, 8'hFF, 1'b0, 1'b0);
    holdLine(1'b1, BIT_CLKS);

    // rx_en dropped during data bit 4.
    base = validCount;
    applyPartial();
    rx_en = 1'b0;
    rxd   = 1'b1;
    repeat (2) @(negedge clk);
    rx_en = 1'b1;
    holdLine(1'b1, 3 * BIT_CLKS);
    checkOutput("rxen_abort_no_frame", validCount, base);
    checkOutput("rxen_abort_data_held", {24'h0, rx_data}, 32'hFF);
    applyStimulus(8'hC3, 1'b0, 1'b1);
    checkFrame("c3_after_rxen", base + 1, 8'hC3, 1'b0, 1'b0);
    holdLine(1'b1, BIT_CLKS);

    // rst pulsed during data bit 4.
    base = validCount;
    applyPartial();
    rst = 1'b1;
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_abort_data", {24'h0, rx_data}, 32'h0);
    checkOutput("rst_abort_valid", {31'h0, rx_valid}, 32'h0);
    rst = 1'b0;
    holdLine(1'b1, 3 * BIT_CLKS);
    checkOutput("rst_abort_no_frame", validCount, base);
    checkOutput("rst_abort_data_zero", {24'h0, rx_data}, 32'h0);
    applyStimulus(8'hC3, 1'b0, 1'b1);
    checkFrame("c3_after_rst", base + 1, 8'hC3, 1'b0, 1'b0);
    holdLine(1'b1, BIT_CLKS);

    checkOutput("final_pulse_width", multiHigh, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
UART receive datapath that sits directly downstream of the Rx baud controller. It consumes the controller's sample_enable strobe (16 strobes per bit period) and oversamples the serial line. It detects and validates the start bit, shifts in data LSB-first, checks parity and the stop bit, and presents one parallel byte per frame with status flags to the host logic.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..8)
OVERSAMPLE, 16, sample_enable strobes per bit period
PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity; 1 = odd parity (ignored when PARITY_EN=0)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rx_en  input  1  receiver enable; low forces IDLE and discards any partial frame
sample_enable  input  1  one-clk strobe from the Rx baud controller, OVERSAMPLE per bit
rxd  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  last received byte; held until the next frame completes
rx_valid  output  1  one-clk pulse when rx_data and the flags update
rx_perror  output  1  parity error of the last frame; updates with rx_valid
rx_ferror  output  1  framing error (stop bit = 0) of the last frame; updates with rx_valid

Behaviour:
- Reset: all outputs 0; state IDLE; tick counter, bit counter and shift register 0; synchronizer flops reset to 1.
- rxd passes through a 2-flop synchronizer (rxd_s). All decisions use rxd_s. Everything except the synchronizer advances only on clk edges where sample_enable=1.
- tick_cnt is 4 bits wide and wraps at OVERSAMPLE-1. bit_cnt counts 0..DATA_BITS-1.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: on a tick with rxd_s=0 and rx_en=1, go to START with tick_cnt=0.
- START: on each tick, tick_cnt+1. At tick_cnt=OVERSAMPLE/2-1 (mid-bit):
  - rxd_s=0: valid start bit; go to DATA with tick_cnt=0 and bit_cnt=0.
  - rxd_s=1: false start/glitch; return to IDLE. No output change.
- DATA: at tick_cnt=OVERSAMPLE-1, sample rxd_s into the shift register MSB end (shift right, LSB-first), set tick_cnt=0 and bit_cnt+1. After bit DATA_BITS-1, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: at tick_cnt=OVERSAMPLE-1, capture the parity bit and compute perr.
  - Even parity: perr = XOR(data bits, parity bit).
  - Odd parity: perr = the inverse of that XOR.
  - Then go to STOP with tick_cnt=0.
- STOP: at tick_cnt=OVERSAMPLE-1, sample the stop bit.
  - On the next clk: rx_data <= shift register, rx_perror <= perr (0 if PARITY_EN=0), rx_ferror <= ~stop, rx_valid=1 for exactly one clk.
  - stop=1: go to IDLE. stop=0: go to BREAK.
- BREAK: wait for a tick with rxd_s=1, then go to IDLE. No start is detected while the line stays low.
- rx_en=0 in any state: go to IDLE on the next clk and drop the partial frame. No rx_valid; outputs hold their last values.
- Latency: rx_valid rises 1 clk after the sample_enable cycle that samples the stop bit. The byte is available ~DATA_BITS+1.5+PARITY_EN bit periods after the falling start edge.
- Back-to-back frames: a start edge detected on the first tick in IDLE after STOP is accepted. There is no extra idle bit requirement.
- rst asserted mid-frame: immediate return to reset values; no rx_valid.
- sample_enable stuck low: FSM frozen; outputs hold.

Test Plan:
- Bench sample_enable every 4 clk, default parameters. Send 0xA5 (bits 1,0,1,0,0,1,0,1, parity 0, stop 1) -> rx_data=0xA5, rx_valid high exactly 1 clk, rx_perror=0, rx_ferror=0.
- Same frame with parity bit 1 -> rx_data=0xA5, rx_perror=1, rx_ferror=0. Next clean 0x3C frame -> rx_perror returns to 0.
- 0x55 frame with stop bit 0, then line held low 3 bit periods, then high, then 0x0F frame -> first: rx_ferror=1, rx_data=0x55. No frame during the low time. Second: rx_data=0x0F, rx_ferror=0.
- rxd low pulse of 4 ticks (shorter than half a bit) -> no rx_valid, FSM back in IDLE. A following 0x81 frame is received correctly.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_valid pulses with rx_data=0x00 and then 0xFF, no errors.
- rx_en dropped, and separately rst pulsed, during data bit 4 of a frame -> no rx_valid. With rst, outputs read 0. A subsequent 0xC3 frame is received correctly.
